// File: rtl/mux_serializer.sv
// Registered N:1 bit-select serializer: captures a word on valid/ready and emits it one bit
// at a time, holding each bit for DIV cycles, LSB-first or MSB-first.
module mux_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SEL_W     = $clog2(DATA_W),
    parameter int unsigned DIV       = 1,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic              inClk,
    input  logic              inRstn,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    output logic              outReady,
    input  logic              inClear,
    output logic              outData,
    output logic              outValid,
    output logic              outStrobe,
    output logic              outLast
);

    localparam int unsigned      DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [SEL_W-1:0] FIRST_IDX = MSB_FIRST ? SEL_W'(DATA_W - 1) : '0;
    localparam logic [SEL_W-1:0] LAST_IDX  = MSB_FIRST ? '0 : SEL_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(DIV - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            stateQ, stateD;
    logic [DATA_W-1:0] wordQ, wordD;
    logic [SEL_W-1:0]  idxQ, idxD, idxNext;
    logic [DIV_W-1:0]  divQ, divD;
    logic              dataQ, dataD;
    logic              validQ, validD;
    logic              strobeQ, strobeD;
    logic              lastQ, lastD;
    logic              bitDone, wordDone, accept;

    assign bitDone  = (divQ == DIV_MAX);
    assign wordDone = bitDone && (idxQ == LAST_IDX);
    assign idxNext  = MSB_FIRST ? (idxQ - SEL_W'(1)) : (idxQ + SEL_W'(1));
    // Ready only when idle or on the very last cycle of a word, so words can abut seamlessly.
    assign outReady = !inClear && ((stateQ == StIdle) || ((stateQ == StShift) && wordDone));
    assign accept   = inValid && outReady;

    always_comb begin
        stateD  = stateQ;
        wordD   = wordQ;
        idxD    = idxQ;
        divD    = divQ;
        dataD   = dataQ;
        validD  = validQ;
        strobeD = 1'b0;
        lastD   = lastQ;
        if (inClear) begin
            stateD = StIdle;
            idxD   = '0;
            divD   = '0;
            validD = 1'b0;
            lastD  = 1'b0;
        end else if (accept) begin
            stateD  = StShift;
            wordD   = inData;
            idxD    = FIRST_IDX;
            divD    = '0;
            dataD   = inData[FIRST_IDX];
            validD  = 1'b1;
            strobeD = 1'b1;
            lastD   = (FIRST_IDX == LAST_IDX);
        end else if (stateQ == StShift) begin
            if (wordDone) begin
                stateD = StIdle;
                divD   = '0;
                validD = 1'b0;
                lastD  = 1'b0;
            end else if (bitDone) begin
                idxD    = idxNext;
                divD    = '0;
                dataD   = wordQ[idxNext];
                strobeD = 1'b1;
                lastD   = (idxNext == LAST_IDX);
            end else begin
                divD = divQ + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            stateQ  <= StIdle;
            wordQ   <= '0;
            idxQ    <= '0;
            divQ    <= '0;
            dataQ   <= 1'b0;
            validQ  <= 1'b0;
            strobeQ <= 1'b0;
            lastQ   <= 1'b0;
        end else begin
            stateQ  <= stateD;
            wordQ   <= wordD;
            idxQ    <= idxD;
            divQ    <= divD;
            dataQ   <= dataD;
            validQ  <= validD;
            strobeQ <= strobeD;
            lastQ   <= lastD;
        end
    end

    assign outData   = dataQ;
    assign outValid  = validQ;
    assign outStrobe = strobeQ;
    assign outLast   = lastQ;

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench for mux_serializer: four instances cover LSB/MSB order, DIV=4 and a
// non-power-of-2 width; expected bits are queued at each accept and popped as they emerge.
module tb_mux_serializer;

    logic       clk;
    logic       rstn;
    logic       clear;
    logic [7:0] din;
    logic [3:0] vIn, vReady, vData, vValid, vStrobe, vLast;
    int         cur;
    int         checks;
    int         errors;
    // Entry: {data, strobe, last, ready}
    logic [3:0] expQ[$];
    logic [3:0] ent;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(1'b0)) u0 (
        .inClk(clk), .inRstn(rstn), .inData(din), .inValid(vIn[0]), .outReady(vReady[0]),
        .inClear(clear), .outData(vData[0]), .outValid(vValid[0]), .outStrobe(vStrobe[0]),
        .outLast(vLast[0])
    );
    mux_serializer #(.DATA_W(8), .DIV(1), .MSB_FIRST(1'b1)) u1 (
        .inClk(clk), .inRstn(rstn), .inData(din), .inValid(vIn[1]), .outReady(vReady[1]),
        .inClear(clear), .outData(vData[1]), .outValid(vValid[1]), .outStrobe(vStrobe[1]),
        .outLast(vLast[1])
    );
    mux_serializer #(.DATA_W(8), .DIV(4), .MSB_FIRST(1'b0)) u2 (
        .inClk(clk), .inRstn(rstn), .inData(din), .inValid(vIn[2]), .outReady(vReady[2]),
        .inClear(clear), .outData(vData[2]), .outValid(vValid[2]), .outStrobe(vStrobe[2]),
        .outLast(vLast[2])
    );
    mux_serializer #(.DATA_W(5), .DIV(1), .MSB_FIRST(1'b0)) u3 (
        .inClk(clk), .inRstn(rstn), .inData(din[4:0]), .inValid(vIn[3]), .outReady(vReady[3]),
        .inClear(clear), .outData(vData[3]), .outValid(vValid[3]), .outStrobe(vStrobe[3]),
        .outLast(vLast[3])
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Monitor: every valid cycle must match the head of the queue; no gaps while queued.
    always @(negedge clk) begin
        if (rstn) begin
            if (vValid[cur]) begin
                if (expQ.size() == 0) begin
                    checkEq("extra_bit", 32'd1, 32'd0);
                end else begin
                    ent = expQ.pop_front();
                    checkEq("data", 32'(vData[cur]), 32'(ent[3]));
                    checkEq("strobe", 32'(vStrobe[cur]), 32'(ent[2]));
                    checkEq("last", 32'(vLast[cur]), 32'(ent[1]));
                    checkEq("ready", 32'(vReady[cur]), 32'(ent[0]));
                end
            end else if (expQ.size() != 0) begin
                checkEq("valid_gap", 32'(vValid[cur]), 32'd1);
            end
        end
    end

    // Drive a word to instance d until accepted; returns 1 ns after the accept edge.
    task automatic sendWord(input int d, input logic [7:0] w, input bit hold, output int waited);
        int wdt, dv;
        bit msb;
        int idx;
        wdt = (d == 3) ? 5 : 8;
        dv  = (d == 2) ? 4 : 1;
        msb = (d == 1);
        waited = 0;
        @(negedge clk);
        din = w;
        vIn[d] = 1'b1;
        while (!vReady[d] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!vReady[d]) begin
            checkEq("accept_timeout", 32'd0, 32'd1);
            vIn[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        for (int b = 0; b < wdt; b++) begin
            idx = msb ? (wdt - 1 - b) : b;
            for (int c = 0; c < dv; c++)
                expQ.push_back({w[idx], c == 0, b == wdt - 1, (b == wdt - 1) && (c == dv - 1)});
        end
        if (!hold) vIn[d] = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checkEq("drain", 32'(expQ.size()), 32'd0);
        expQ.delete();
        @(negedge clk);
        checkEq("idle_valid", 32'(vValid[cur]), 32'd0);
        checkEq("idle_ready", 32'(vReady[cur]), 32'd1);
    endtask

    initial begin
        int w;
        checks = 0;
        errors = 0;
        cur    = 0;
        rstn   = 1'b0;
        clear  = 1'b0;
        din    = '0;
        vIn    = '0;
        repeat (2) @(negedge clk);
        checkEq("rst_outs", {vValid, vData, vStrobe, vLast}, 32'h0);
        checkEq("rst_ready", 32'(vReady), 32'hF);
        rstn = 1'b1;

        cur = 0; sendWord(0, 8'hB1, 1'b0, w); drain();
        cur = 1; sendWord(1, 8'hB1, 1'b0, w); drain();
        cur = 2; sendWord(2, 8'h0F, 1'b0, w); drain();

        // Back-to-back with inValid held: second accept lands on the eighth output cycle.
        cur = 0;
        sendWord(0, 8'hFF, 1'b1, w);
        sendWord(0, 8'h00, 1'b0, w);
        checkEq("b2b_wait", 32'(w), 32'd7);
        drain();

        // Abort on the third bit, then a fresh word.
        sendWord(0, 8'hB1, 1'b0, w);
        repeat (3) @(negedge clk);
        clear = 1'b1;
        #1;
        checkEq("clr_ready", 32'(vReady[0]), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkEq("clr_valid", 32'(vValid[0]), 32'd0);
        checkEq("clr_last", 32'(vLast[0]), 32'd0);
        sendWord(0, 8'h01, 1'b0, w);
        drain();

        // Asynchronous reset between edges, mid-word.
        sendWord(0, 8'hA5, 1'b0, w);
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checkEq("arst_valid", 32'(vValid[0]), 32'd0);
        checkEq("arst_data", 32'(vData[0]), 32'd0);
        checkEq("arst_last", 32'(vLast[0]), 32'd0);
        expQ.delete();
        #4;
        rstn = 1'b1;
        @(negedge clk);
        checkEq("arst_ready", 32'(vReady[0]), 32'd1);
        checkEq("arst_idle", 32'(vValid[0]), 32'd0);
        repeat (10) @(negedge clk);

        cur = 3; sendWord(3, 8'h15, 1'b0, w); drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
